jt08_wr_seq: RTL

Host-side register-write sequencer for the YM2608 core. It accepts (bank, register, value) commands into a small FIFO and drives the chip's CPU bus (`din`, `addr`, `cs_n`, `wr_n`, `rd_n`, `dout`) as the bus initiator. Each command becomes an address write followed by a data write, then a wait until the chip is ready again. It sits between the system's register-stream source (CPU bridge or VGM/S98 player) and the sound core.

---
 rtl/jt08_wr_seq_if.sv | 31 +++
 rtl/jt08_wr_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jt08_wr_seq_if.sv
// Bus bundle for jt08_wr_seq.
//   Command side : cmd_valid/cmd_ready handshake carrying {cmd_bank, cmd_reg, cmd_val}
//   Status       : idle, tmo_err
//   Chip side    : ym_din, ym_addr, ym_cs_n, ym_wr_n, ym_rd_n (to chip), ym_dout (from chip)
// modport master : the sequencer (bus initiator towards the YM2608 core)
// modport slave  : the environment (command source plus sound core)
interface jt08_wr_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_bank;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_val;
   logic       idle;
   logic       tmo_err;
   logic [7:0] ym_din;
   logic [1:0] ym_addr;
   logic       ym_cs_n;
   logic       ym_wr_n;
   logic       ym_rd_n;
   logic [7:0] ym_dout;

   modport master (
      input  cmd_valid, cmd_bank, cmd_reg, cmd_val, ym_dout,
      output cmd_ready, idle, tmo_err, ym_din, ym_addr, ym_cs_n, ym_wr_n, ym_rd_n
   );

   modport slave (
      output cmd_valid, cmd_bank, cmd_reg, cmd_val, ym_dout,
      input  cmd_ready, idle, tmo_err, ym_din, ym_addr, ym_cs_n, ym_wr_n, ym_rd_n
   );
endinterface

// File: rtl/jt08_wr_seq.sv
// Host-side register-write sequencer for the YM2608 core.
// Commands {bank, reg, val} are queued in a 2^FIFO_AW deep FIFO and replayed on the
// chip CPU bus as an address write followed by a data write, then a wait.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   cen  - bus clock enable, every bus phase advances only on cen
//   bus  - jt08_wr_seq_if.master: command handshake, idle/tmo_err status, chip bus
// Build option: define JT08_WR_SEQ_BUSY_POLL_EN to replace the fixed WAIT_CYC wait
// with status-read busy polling (bounded by TIMEOUT reads, sticky tmo_err).
module jt08_wr_seq #(
   parameter int FIFO_AW  = 3,
   parameter int WAIT_CYC = 24,
   parameter int TIMEOUT  = 255
) (
   input logic           clk,
   input logic           rst,
   input logic           cen,
   jt08_wr_seq_if.master bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_WAIT, S_R_SET, S_R_SMP
   } state_t;

   state_t             r_state, w_state_nx;
   logic [16:0]        r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wp, r_rp;
   logic [CW-1:0]      r_cnt, w_cnt_nx;
   logic               w_push, w_pop, w_full, w_empty;
   logic [16:0]        r_cmd;
   logic               r_cs_n, r_wr_n, w_cs_n, w_wr_n;
   logic [1:0]         r_addr, w_addr;
   logic [7:0]         r_din, w_din;
   logic               r_idle;
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
   logic               r_rd_n, w_rd_n;
   logic [7:0]         r_pcnt, w_pcnt_nx;
   logic               r_tmo, w_tmo_set;
`else
   localparam int WW = $clog2(WAIT_CYC + 1);
   logic [WW-1:0]      r_wcnt, w_wcnt_nx;
`endif

   assign w_full   = (r_cnt == CW'(DEPTH));
   assign w_empty  = (r_cnt == '0);
   assign w_push   = bus.cmd_valid && !w_full;
   assign w_cnt_nx = r_cnt + CW'(w_push) - CW'(w_pop);

   assign bus.cmd_ready = !w_full;
   assign bus.idle      = r_idle;
   assign bus.ym_cs_n   = r_cs_n;
   assign bus.ym_wr_n   = r_wr_n;
   assign bus.ym_addr   = r_addr;
   assign bus.ym_din    = r_din;
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
   assign bus.ym_rd_n   = r_rd_n;
   assign bus.tmo_err   = r_tmo;
`else
   assign bus.ym_rd_n   = 1'b1;
   assign bus.tmo_err   = 1'b0;
`endif

   // Bus strobes are registered from the current state, so every phase is driven
   // one cen cycle after the state is entered; addr/din/strobe move together.
   always_comb begin
      w_state_nx = r_state;
      w_pop      = 1'b0;
      w_cs_n     = 1'b1;
      w_wr_n     = 1'b1;
      w_addr     = r_addr;
      w_din      = r_din;
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
      w_rd_n     = 1'b1;
      w_pcnt_nx  = r_pcnt;
      w_tmo_set  = 1'b0;
`else
      w_wcnt_nx  = r_wcnt;
`endif
      unique case (r_state)
         S_IDLE: if (cen && !w_empty) begin
            w_pop      = 1'b1;
            w_state_nx = S_A_SET;
         end
         S_A_SET, S_A_STB, S_A_HLD: begin
            w_cs_n = 1'b0;
            w_wr_n = (r_state != S_A_STB);
            w_addr = {r_cmd[16], 1'b0};
            w_din  = r_cmd[15:8];
            if (cen) begin
               if (r_state == S_A_SET)      w_state_nx = S_A_STB;
               else if (r_state == S_A_STB) w_state_nx = S_A_HLD;
               else                         w_state_nx = S_D_SET;
            end
         end
         S_D_SET, S_D_STB, S_D_HLD: begin
            w_cs_n = 1'b0;
            w_wr_n = (r_state != S_D_STB);
            w_addr = {r_cmd[16], 1'b1};
            w_din  = r_cmd[7:0];
            if (cen) begin
               if (r_state == S_D_SET)      w_state_nx = S_D_STB;
               else if (r_state == S_D_STB) w_state_nx = S_D_HLD;
               else begin
                  w_state_nx = S_WAIT;
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
                  w_pcnt_nx  = '0;
`else
                  w_wcnt_nx  = '0;
`endif
               end
            end
         end
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
         // WAIT keeps cs_n high for one cen cycle between accesses.
         S_WAIT: if (cen) w_state_nx = S_R_SET;
         S_R_SET, S_R_SMP: begin
            w_cs_n = 1'b0;
            w_rd_n = 1'b0;
            w_addr = {r_cmd[16], 1'b0};
            if (cen) begin
               if (r_state == S_R_SET) w_state_nx = S_R_SMP;
               else if (!bus.ym_dout[7]) w_state_nx = S_IDLE;
               else begin
                  w_pcnt_nx = r_pcnt + 8'd1;
                  if (r_pcnt == 8'(TIMEOUT - 1)) begin
                     w_tmo_set  = 1'b1;
                     w_state_nx = S_IDLE;
                  end else begin
                     w_state_nx = S_WAIT;
                  end
               end
            end
         end
`else
         S_WAIT: if (cen) begin
            if (r_wcnt == WW'(WAIT_CYC - 1)) w_state_nx = S_IDLE;
            else                             w_wcnt_nx  = r_wcnt + WW'(1);
         end
`endif
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cs_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_addr  <= '0;
         r_din   <= '0;
         r_cmd   <= '0;
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
         r_rd_n  <= 1'b1;
         r_pcnt  <= '0;
         r_tmo   <= 1'b0;
`else
         r_wcnt  <= '0;
`endif
      end else if (cen) begin
         r_state <= w_state_nx;
         r_cs_n  <= w_cs_n;
         r_wr_n  <= w_wr_n;
         r_addr  <= w_addr;
         r_din   <= w_din;
         if (w_pop) r_cmd <= r_mem[r_rp];
`ifdef JT08_WR_SEQ_BUSY_POLL_EN
         r_rd_n  <= w_rd_n;
         r_pcnt  <= w_pcnt_nx;
         if (w_tmo_set) r_tmo <= 1'b1;
`else
         r_wcnt  <= w_wcnt_nx;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {bus.cmd_bank, bus.cmd_reg, bus.cmd_val};
   end

   // idle looks ahead at next state and next count so it rises on the edge that enters IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_idle <= 1'b1;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_cnt  <= w_cnt_nx;
         r_idle <= (w_state_nx == S_IDLE) && (w_cnt_nx == '0);
      end
   end
endmodule
